// File: rtl/multi_port_free_list.sv
// multi_port_free_list: multi-push / multi-pop circular free list with show-ahead pop lanes.
// Optional read-pointer checkpoint for mispredict recovery is enabled by defining FREE_LIST_CKPT_EN.
module multi_port_free_list #(
  parameter int DATA_WIDTH = 5,
  parameter int DATA_DEPTH = 32,
  parameter int WR_PORTS   = 8,
  parameter int RD_PORTS   = 4,
  parameter bit INIT_FULL  = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WR_PORTS-1:0]            wr_en,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data,
  output logic                           wr_ready,
  input  logic [RD_PORTS-1:0]            rd_en,
`ifdef FREE_LIST_CKPT_EN
  input  logic                           ckpt_save,
  input  logic                           ckpt_restore,
  input  logic                           ckpt_release,
  output logic                           ckpt_live,
`endif
  output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [RD_PORTS-1:0]            rd_valid,
  output logic [$clog2(DATA_DEPTH):0]    count,
  output logic                           empty,
  output logic                           full
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DATA_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         eff_rd_ptr, space, wr_cnt, pop_cnt;
  logic [AW-1:0]         wr_offs, rd_addr;
  logic                  push_acc;

`ifdef FREE_LIST_CKPT_EN
  logic [PW-1:0] ckpt_ptr_q, ckpt_ptr_d;
  logic          ckpt_live_q, ckpt_live_d;

  // While a checkpoint is live, the entries popped since the save still own their slots.
  assign eff_rd_ptr = ckpt_live_q ? ckpt_ptr_q : rd_ptr_q;
  assign ckpt_live  = ckpt_live_q;
`else
  assign eff_rd_ptr = rd_ptr_q;
`endif

  assign count    = wr_ptr_q - rd_ptr_q;
  assign space    = PW'(DATA_DEPTH) - (wr_ptr_q - eff_rd_ptr);
  assign empty    = (count == '0);
  assign full     = (space == '0);
  assign wr_ready = (space >= wr_cnt);
  assign push_acc = wr_ready && (wr_en != '0);

  always_comb begin
    wr_cnt = '0;
    for (int k = 0; k < WR_PORTS; k++) wr_cnt = wr_cnt + PW'(wr_en[k]);
  end

  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    rd_addr  = '0;
    pop_cnt  = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_addr     = rd_ptr_q[AW-1:0] + AW'(i);
      rd_valid[i] = (count > PW'(i));
      if (rd_valid[i]) begin
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr];
        if (rd_en[i]) pop_cnt = pop_cnt + PW'(1);
      end
    end
  end

  // Enabled lanes are compacted into consecutive slots in lane order.
  always_comb begin
    mem_d    = mem_q;
    wr_offs  = '0;
    wr_ptr_d = wr_ptr_q;
    if (push_acc) begin
      for (int k = 0; k < WR_PORTS; k++) begin
        if (wr_en[k]) begin
          mem_d[wr_ptr_q[AW-1:0] + wr_offs] = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
          wr_offs = wr_offs + AW'(1);
        end
      end
      wr_ptr_d = wr_ptr_q + wr_cnt;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + pop_cnt;
`ifdef FREE_LIST_CKPT_EN
    ckpt_ptr_d  = ckpt_ptr_q;
    ckpt_live_d = ckpt_live_q;
    if (ckpt_restore) begin
      if (ckpt_live_q) begin
        rd_ptr_d    = ckpt_ptr_q;
        ckpt_live_d = 1'b0;
      end
    end else if (ckpt_release) begin
      ckpt_live_d = 1'b0;
    end else if (ckpt_save) begin
      ckpt_ptr_d  = rd_ptr_q + pop_cnt;
      ckpt_live_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= INIT_FULL ? PW'(DATA_DEPTH) : '0;
      for (int i = 0; i < DATA_DEPTH; i++) mem_q[i] <= INIT_FULL ? DATA_WIDTH'(i) : '0;
`ifdef FREE_LIST_CKPT_EN
      ckpt_ptr_q  <= '0;
      ckpt_live_q <= 1'b0;
`endif
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      mem_q    <= mem_d;
`ifdef FREE_LIST_CKPT_EN
      ckpt_ptr_q  <= ckpt_ptr_d;
      ckpt_live_q <= ckpt_live_d;
`endif
    end
  end

endmodule

// File: tb/tb_multi_port_free_list.sv
// Testbench for multi_port_free_list: directed scenarios plus randomized traffic against a queue model.
// Checkpoint scenarios are compiled in when FREE_LIST_CKPT_EN is defined.
module tb_multi_port_free_list;
  localparam int DW = 5, DEPTH = 32, WP = 8, RP = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WP-1:0]     wr_en = '0;
  logic [WP*DW-1:0]  wr_data = '0;
  logic              wr_ready;
  logic [RP-1:0]     rd_en = '0;
  logic [RP*DW-1:0]  rd_data;
  logic [RP-1:0]     rd_valid;
  logic [5:0]        count;
  logic              empty, full;
  logic              sv_r = 1'b0, rs_r = 1'b0, rl_r = 1'b0;
`ifdef FREE_LIST_CKPT_EN
  logic              ckpt_live;
`endif

  int checks = 0;
  int errors = 0;

  // model: queue of poppable tags, plus tags popped since a live checkpoint was saved
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] ck_q[$];
  bit            ck_live;
  logic [RP*DW-1:0] rst_data;

  multi_port_free_list dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en),
`ifdef FREE_LIST_CKPT_EN
    .ckpt_save(sv_r), .ckpt_restore(rs_r), .ckpt_release(rl_r), .ckpt_live(ckpt_live),
`endif
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  function automatic int popc(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int m_space();
    return DEPTH - m_q.size() - (ck_live ? ck_q.size() : 0);
  endfunction

  function automatic logic [RP-1:0] exp_valid();
    logic [RP-1:0] v = '0;
    for (int i = 0; i < RP; i++) v[i] = (m_q.size() > i);
    return v;
  endfunction

  function automatic logic [RP*DW-1:0] exp_data();
    logic [RP*DW-1:0] d = '0;
    for (int i = 0; i < RP; i++) if (i < m_q.size()) d[i*DW +: DW] = m_q[i];
    return d;
  endfunction

  function automatic bit exp_ready();
    return m_space() >= popc(32'(wr_en));
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < DEPTH; i++) m_q.push_back(DW'(i));
    ck_q.delete();
    ck_live = 1'b0;
  endtask

  task automatic model_commit();
    bit acc;
    int npop;
    logic [DW-1:0] x;
    acc = exp_ready() && (wr_en != '0);
    if (rs_r && ck_live) begin
      for (int i = ck_q.size() - 1; i >= 0; i--) m_q.push_front(ck_q[i]);
      ck_q.delete();
      ck_live = 1'b0;
    end else begin
      npop = popc(32'(rd_en));
      if (npop > m_q.size()) npop = m_q.size();
      repeat (npop) begin
        x = m_q.pop_front();
        if (ck_live) ck_q.push_back(x);
      end
      if (!rs_r) begin
        if (rl_r) ck_live = 1'b0;
        else if (sv_r) begin
          ck_q.delete();
          ck_live = 1'b1;
        end
      end
    end
    if (acc) for (int k = 0; k < WP; k++) if (wr_en[k]) m_q.push_back(wr_data[k*DW +: DW]);
  endtask

  // advance one clock with the inputs currently driven; returns at posedge+1 with inputs idle
  task automatic commit();
    @(posedge clk);
    model_commit();
    #1;
    wr_en = '0; rd_en = '0; sv_r = 1'b0; rs_r = 1'b0; rl_r = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 4'hF;
      commit();
    end
  endtask

  task automatic test_reset();
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL reset_count: got %0d expected 32", count); end
    checks++; if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL reset_flags: got full=%0b empty=%0b expected full=1 empty=0", full, empty); end
    checks++; if (rd_valid !== 4'hF) begin errors++; $display("FAIL reset_rd_valid: got %h expected f", rd_valid); end
    checks++; if (rd_data !== rst_data) begin errors++; $display("FAIL reset_rd_data: got %h expected %h", rd_data, rst_data); end
    wr_en = 8'h01; wr_data = 40'h1F;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %0b expected 0", wr_ready); end
    commit();
    checks++; if (count !== 6'd32 || rd_data !== rst_data) begin errors++; $display("FAIL full_push_no_change: got count=%0d data=%h expected 32 %h", count, rd_data, rst_data); end
  endtask

  task automatic test_pop_compact();
    logic [DW-1:0] a, b, c;
    logic [DW-1:0] popped[$];
    a = DW'($urandom); b = DW'($urandom); c = DW'($urandom);
    rd_en = 4'b0111;
    commit();
    checks++; if (count !== 6'd29) begin errors++; $display("FAIL pop3_count: got %0d expected 29", count); end
    checks++; if (rd_data[DW-1:0] !== 5'd3) begin errors++; $display("FAIL pop3_lane0: got %0d expected 3", rd_data[DW-1:0]); end
    wr_en = 8'b1010_0001;
    wr_data = '0;
    wr_data[0*DW +: DW] = a; wr_data[5*DW +: DW] = b; wr_data[7*DW +: DW] = c;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL push3_wr_ready: got %0b expected 1", wr_ready); end
    commit();
    checks++; if (count !== 6'd32 || full !== 1'b1) begin errors++; $display("FAIL push3_count: got %0d full=%0b expected 32 full=1", count, full); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd_data !== exp_data()) begin errors++; $display("FAIL drain_data: got %h expected %h", rd_data, exp_data()); end
      for (int j = 0; j < RP; j++) popped.push_back(rd_data[j*DW +: DW]);
      rd_en = 4'hF;
      commit();
    end
    checks++; if (popped.size() != 32 || popped[29] !== a || popped[30] !== b || popped[31] !== c) begin
      errors++; $display("FAIL compaction_order: got %0d %0d %0d expected %0d %0d %0d", popped[29], popped[30], popped[31], a, b, c);
    end
  endtask

  task automatic test_drain_partial();
    do_reset();
    pop_n(7);
    rd_en = 4'b0011;
    commit();
    checks++; if (count !== 6'd2) begin errors++; $display("FAIL drain_to2: got %0d expected 2", count); end
    rd_en = 4'hF;
    #1;
    checks++; if (rd_valid !== 4'b0011) begin errors++; $display("FAIL partial_valid: got %b expected 0011", rd_valid); end
    commit();
    checks++; if (count !== 6'd0 || empty !== 1'b1) begin errors++; $display("FAIL over_pop_empty: got count=%0d empty=%0b expected 0 1", count, empty); end
    checks++; if (rd_valid !== 4'h0 || rd_data !== '0) begin errors++; $display("FAIL empty_outputs: got valid=%h data=%h expected 0 0", rd_valid, rd_data); end
  endtask

  task automatic test_wrap();
    logic [RP*DW-1:0] v;
    do_reset();
    pop_n(8);
    for (int i = 0; i < 5; i++) begin
      wr_en = 8'h3F; wr_data = {$urandom, $urandom};
      commit();
    end
    pop_n(7);
    rd_en = 4'b0011;
    commit();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_setup_empty: got %0b expected 1", empty); end
    v = 20'($urandom);
    wr_en = 8'h0F; wr_data = '0; wr_data[RP*DW-1:0] = v;
    commit();
    checks++; if (count !== 6'd4 || rd_data !== v) begin errors++; $display("FAIL wrap_data: got count=%0d data=%h expected 4 %h", count, rd_data, v); end
    rd_en = 4'hF;
    commit();
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL wrap_empty: got empty=%0b full=%0b expected 1 0", empty, full); end
  endtask

  task automatic test_simul_push_pop();
    do_reset();
    rd_en = 4'b0011;
    commit();
    rd_en = 4'hF; wr_en = 8'h07; wr_data = {$urandom, $urandom};
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL prepop_space_ready: got %0b expected 0", wr_ready); end
    commit();
    checks++; if (count !== 6'd26 || rd_data !== exp_data()) begin errors++; $display("FAIL simul_result: got count=%0d data=%h expected 26 %h", count, rd_data, exp_data()); end
  endtask

`ifdef FREE_LIST_CKPT_EN
  task automatic test_ckpt();
    logic [RP*DW-1:0] saved;
    do_reset();
    pop_n(8);
    for (int i = 0; i < 3; i++) begin
      wr_en = 8'hFF; wr_data = {$urandom, $urandom};
      commit();
    end
    wr_en = 8'h7F; wr_data = {$urandom, $urandom};
    commit();
    rd_en = 4'hF; commit();
    rd_en = 4'b0001; commit();
    saved = exp_data();
    sv_r = 1'b1;
    commit();
    checks++; if (ckpt_live !== 1'b1) begin errors++; $display("FAIL ckpt_save_live: got %0b expected 1", ckpt_live); end
    rd_en = 4'hF; commit();
    rd_en = 4'b0011; commit();
    wr_en = 8'h3F; wr_data = {$urandom, $urandom};
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ckpt_push_ready: got %0b expected 1", wr_ready); end
    commit();
    checks++; if (full !== 1'b1 || count !== 6'd26) begin errors++; $display("FAIL ckpt_full: got full=%0b count=%0d expected 1 26", full, count); end
    rs_r = 1'b1; rd_en = 4'hF;
    commit();
    checks++; if (ckpt_live !== 1'b0 || count !== 6'd32) begin errors++; $display("FAIL ckpt_restore: got live=%0b count=%0d expected 0 32", ckpt_live, count); end
    checks++; if (rd_data !== saved) begin errors++; $display("FAIL ckpt_tags_back: got %h expected %h", rd_data, saved); end
  endtask
`endif

  task automatic test_random();
    int n;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      wr_en = (i % 200 < 100) ? WP'($urandom & $urandom & $urandom) : WP'($urandom);
      wr_data = {$urandom, $urandom};
      n = $urandom_range(0, RP);
      rd_en = RP'((1 << n) - 1);
`ifdef FREE_LIST_CKPT_EN
      sv_r = ($urandom_range(0, 15) == 0);
      rs_r = ($urandom_range(0, 19) == 0);
      rl_r = ($urandom_range(0, 29) == 0);
`endif
      #1;
      checks++; if (wr_ready !== exp_ready()) begin errors++; $display("FAIL rand_wr_ready: got %0b expected %0b", wr_ready, exp_ready()); end
      checks++; if (rd_valid !== exp_valid()) begin errors++; $display("FAIL rand_rd_valid: got %h expected %h", rd_valid, exp_valid()); end
      checks++; if (rd_data !== exp_data()) begin errors++; $display("FAIL rand_rd_data: got %h expected %h", rd_data, exp_data()); end
      checks++; if (count !== 6'(m_q.size())) begin errors++; $display("FAIL rand_count: got %0d expected %0d", count, m_q.size()); end
      checks++; if (full !== (m_space() == 0) || empty !== (m_q.size() == 0)) begin
        errors++; $display("FAIL rand_flags: got full=%0b empty=%0b expected %0b %0b", full, empty, m_space() == 0, m_q.size() == 0);
      end
`ifdef FREE_LIST_CKPT_EN
      checks++; if (ckpt_live !== ck_live) begin errors++; $display("FAIL rand_ckpt_live: got %0b expected %0b", ckpt_live, ck_live); end
`endif
      commit();
    end
  endtask

  task automatic test_async_reset();
    pop_n(3);
    wr_en = 8'hFF; wr_data = {$urandom, $urandom}; rd_en = 4'hF;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (count !== 6'd32 || full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL async_rst_state: got count=%0d full=%0b empty=%0b expected 32 1 0", count, full, empty); end
    checks++; if (rd_valid !== 4'hF || rd_data !== rst_data) begin errors++; $display("FAIL async_rst_rd: got valid=%h data=%h expected f %h", rd_valid, rd_data, rst_data); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL async_rst_ready: got %0b expected 0", wr_ready); end
    @(posedge clk);
    #1;
    checks++; if (count !== 6'd32 || rd_data !== rst_data) begin errors++; $display("FAIL rst_held_no_change: got count=%0d data=%h expected 32 %h", count, rd_data, rst_data); end
    wr_en = '0; rd_en = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rd_data !== exp_data() || count !== 6'd32) begin errors++; $display("FAIL post_rst: got count=%0d data=%h expected 32 %h", count, rd_data, exp_data()); end
  endtask

  initial begin
    rst_data = {5'd3, 5'd2, 5'd1, 5'd0};
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_pop_compact();
    test_drain_partial();
    test_wrap();
    test_simul_push_pop();
`ifdef FREE_LIST_CKPT_EN
    test_ckpt();
`endif
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
